// File: rtl/facto_drv_pkg.sv
// Shared definitions for the factorial-core bus master: register offsets, FSM states, bus beat.
// Latency: none (package only).
// Backpressure: n/a.
package facto_drv_pkg;

    // Register offsets relative to the core base address
    localparam logic [15:0] OFF_START   = 16'h0000;
    localparam logic [15:0] OFF_CLEAR   = 16'h0008;
    localparam logic [15:0] OFF_OPDONE  = 16'h0010;
    localparam logic [15:0] OFF_INTREN  = 16'h0018;
    localparam logic [15:0] OFF_OPERAND = 16'h0020;
    localparam logic [15:0] OFF_RESH    = 16'h0028;
    localparam logic [15:0] OFF_RESL    = 16'h0030;

    typedef enum logic [3:0] {
        IDLE,
        CLR1,
        CLR0,
        WINT,
        WOPD,
        WSTART,
        WAIT,
        POLL_A,
        POLL_D,
        RDH_A,
        RDH_D,
        RDL_A,
        RDL_D,
        DONE
    } state_t;

    // One cycle of the core's register bus
    typedef struct packed {
        logic        sel;
        logic        wr;
        logic [15:0] addr;
        logic [63:0] wdata;
    } bus_t;

    function automatic bus_t bus_write(input logic [15:0] addr, input logic [63:0] data);
        bus_t b;
        b.sel   = 1'b1;
        b.wr    = 1'b1;
        b.addr  = addr;
        b.wdata = data;
        return b;
    endfunction

    // Reads drive wdata to zero; the core ignores it.
    function automatic bus_t bus_read(input logic [15:0] addr);
        bus_t b;
        b.sel   = 1'b1;
        b.wr    = 1'b0;
        b.addr  = addr;
        b.wdata = 64'd0;
        return b;
    endfunction

endpackage

// File: rtl/facto_drv_wdog.sv
// Wait-phase watchdog: 16-bit counter, cleared by clr, counts while en; expired flags the last allowed cycle.
// Latency: expired is combinational from the count, so the wait phase lasts exactly LIMIT cycles.
// Backpressure: none.
// Ports: clk, reset (sync, active-high), clr (restart count), en (count this cycle), expired (out).
module facto_drv_wdog #(
    parameter logic [15:0] LIMIT = 16'd1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [15:0] LAST = LIMIT - 16'd1;

    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= 16'd0;
        end else if (en && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'd1;
        end
    end

    // cnt equals the number of wait cycles already spent; when it reaches
    // LIMIT-1 the current cycle is the last one allowed.
    assign expired = en && (cnt >= LAST);

endmodule

// File: rtl/facto_driver.sv
// Bus master for the factorial core: takes an operand job, programs the core, waits, reads back a 128-bit result.
// Latency: 1 accept + 5 writes + wait phase + 4 reads, then res_valid (wait phase bounded by TIMEOUT_CYC).
// Backpressure: job_ready only in IDLE; result held in DONE until res_ready.
// Ports: clk, reset (sync, active-high); job_valid/job_ready/job_operand; res_valid/res_ready/res_data/res_err;
//        m_sel/m_wr/m_addr/m_wdata/m_rdata (core register bus, read latency 1); interrupt; busy.
// Build option: FACTO_DRV_IRQ_EN defined -> interrupt-driven wait; undefined -> opdone polling.
module facto_driver #(
    parameter logic [15:0] BASE_ADDR   = 16'h7000,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [63:0]  job_operand,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] res_data,
    output logic         res_err,
    output logic         m_sel,
    output logic         m_wr,
    output logic [15:0]  m_addr,
    output logic [63:0]  m_wdata,
    input  logic [63:0]  m_rdata,
    input  logic         interrupt,
    output logic         busy
);

    import facto_drv_pkg::*;

`ifdef FACTO_DRV_IRQ_EN
    localparam logic [63:0] INTR_EN_VAL = 64'd1;
`else
    localparam logic [63:0] INTR_EN_VAL = 64'd0;
    // Polled build never looks at the interrupt line.
    logic unused_interrupt;
    assign unused_interrupt = interrupt;
`endif

    state_t       state;
    state_t       state_nxt;
    bus_t         bus_q;
    bus_t         bus_nxt;
    logic [63:0]  op_q;
    logic [63:0]  res_h;
    logic [63:0]  res_l;
    logic         in_wait;
    logic         expired;

    assign in_wait = (state == WAIT) || (state == POLL_A) || (state == POLL_D);

    facto_drv_wdog #(
        .LIMIT (16'(TIMEOUT_CYC))
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (state == WSTART),
        .en      (in_wait),
        .expired (expired)
    );

    // Next-state logic. Completion is checked before the watchdog so that a
    // completion seen on the final allowed cycle still produces a result.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (job_valid) state_nxt = CLR1;
            CLR1:   state_nxt = CLR0;
            CLR0:   state_nxt = WINT;
            WINT:   state_nxt = WOPD;
            WOPD:   state_nxt = WSTART;
            WSTART: state_nxt = WAIT;
`ifdef FACTO_DRV_IRQ_EN
            WAIT: begin
                if (interrupt)    state_nxt = RDH_A;
                else if (expired) state_nxt = DONE;
            end
`else
            WAIT:   state_nxt = expired ? DONE : POLL_A;
`endif
            POLL_A: state_nxt = expired ? DONE : POLL_D;
            POLL_D: begin
                if (m_rdata[0])   state_nxt = RDH_A;
                else if (expired) state_nxt = DONE;
                else              state_nxt = POLL_A;
            end
            RDH_A:  state_nxt = RDH_D;
            RDH_D:  state_nxt = RDL_A;
            RDL_A:  state_nxt = RDL_D;
            RDL_D:  state_nxt = DONE;
            DONE:   if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus beat is decoded from the next state and registered, so m_* always
    // describe the beat belonging to the current state.
    always_comb begin
        bus_nxt = '0;
        case (state_nxt)
            CLR1:           bus_nxt = bus_write(BASE_ADDR + OFF_CLEAR,   64'd1);
            CLR0:           bus_nxt = bus_write(BASE_ADDR + OFF_CLEAR,   64'd0);
            WINT:           bus_nxt = bus_write(BASE_ADDR + OFF_INTREN,  INTR_EN_VAL);
            WOPD:           bus_nxt = bus_write(BASE_ADDR + OFF_OPERAND, op_q);
            WSTART:         bus_nxt = bus_write(BASE_ADDR + OFF_START,   64'd1);
            POLL_A, POLL_D: bus_nxt = bus_read(BASE_ADDR + OFF_OPDONE);
            RDH_A, RDH_D:   bus_nxt = bus_read(BASE_ADDR + OFF_RESH);
            RDL_A, RDL_D:   bus_nxt = bus_read(BASE_ADDR + OFF_RESL);
            default:        bus_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bus_q   <= '0;
            op_q    <= 64'd0;
            res_h   <= 64'd0;
            res_l   <= 64'd0;
            res_err <= 1'b0;
        end else begin
            state <= state_nxt;
            bus_q <= bus_nxt;
            if (state == IDLE && job_valid) begin
                op_q    <= job_operand;
                res_err <= 1'b0;
            end
            // Read data arrives one cycle after the address; sample at the end of the data cycle.
            if (state == RDH_D) res_h <= m_rdata;
            if (state == RDL_D) res_l <= m_rdata;
            // Only the watchdog can move from the wait phase straight to DONE.
            if (in_wait && state_nxt == DONE) begin
                res_h   <= 64'd0;
                res_l   <= 64'd0;
                res_err <= 1'b1;
            end
        end
    end

    assign job_ready = (state == IDLE);
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign res_data  = {res_h, res_l};
    assign m_sel     = bus_q.sel;
    assign m_wr      = bus_q.wr;
    assign m_addr    = bus_q.addr;
    assign m_wdata   = bus_q.wdata;

endmodule
